// File: rtl/i2si.sv
// i2si - I2S slave receiver (Philips format, MSB first).
//
// Brings the external bit clock, word select and serial data into the clk
// domain and deserializes one left/right word pair per frame. Each completed
// pair is offered to the downstream filter with a ready-to-send /
// ready-to-receive handshake. A pair that completes while the previous pair
// is still waiting is dropped and the sticky overrun flag is raised.
//
// Ports:
//   clk, rst_n          master clock, asynchronous active-low reset
//   i_i2si_en           receiver enable; low forces resynchronisation
//   i_i2si_sck/ws/sd    external I2S bit clock, word select, serial data
//   o_i2si_filt_lft/rgt held left/right samples
//   o_i2si_filt_rts     held pair valid (ready to send)
//   i_filt_i2si_rtr     filter ready to receive
//   o_i2si_ovr          sticky overrun flag
//   i_i2si_ovr_clr      clears the overrun flag
//
// state  | meaning
// SYNC   | waiting for a ws 1->0 edge; all bits discarded
// LEFT   | collecting the left-channel word
// RIGHT  | collecting the right-channel word
module i2si #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_i2si_en,
  input  logic              i_i2si_sck,
  input  logic              i_i2si_ws,
  input  logic              i_i2si_sd,
  output logic [DATA_W-1:0] o_i2si_filt_lft,
  output logic [DATA_W-1:0] o_i2si_filt_rgt,
  output logic              o_i2si_filt_rts,
  input  logic              i_filt_i2si_rtr,
  output logic              o_i2si_ovr,
  input  logic              i_i2si_ovr_clr
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DATA_W);
  localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ws_sync;
  logic [SYNC_STAGES-1:0] r_sd_sync;
  logic                   r_sck_d;
  logic                   r_sck_rise;
  logic                   r_ws_smp;
  logic                   r_sd_smp;
  logic                   r_ws_prev;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DATA_W-1:0]      r_shreg;
  logic [DATA_W-1:0]      w_shreg_nxt;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [DATA_W-1:0]      r_lft_hold;
  logic [DATA_W-1:0]      w_lft_nxt;
  logic                   w_frame_done;

  logic [DATA_W-1:0]      w_mask;
  logic [DATA_W-1:0]      w_word;
  logic                   w_ws_chg;
  logic                   w_xfer;
  logic                   w_load;
  logic                   w_ovr_evt;

  logic [DATA_W-1:0]      r_out_lft;
  logic [DATA_W-1:0]      r_out_rgt;
  logic                   r_rts;
  logic                   r_ovr;

  // The rise pulse and the ws/sd samples are registered from the same
  // synchronizer stage so they stay aligned with each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync <= '0;
      r_ws_sync  <= '0;
      r_sd_sync  <= '0;
      r_sck_d    <= 1'b0;
      r_sck_rise <= 1'b0;
      r_ws_smp   <= 1'b0;
      r_sd_smp   <= 1'b0;
      r_ws_prev  <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i_i2si_sck};
      r_ws_sync  <= {r_ws_sync[SYNC_STAGES-2:0], i_i2si_ws};
      r_sd_sync  <= {r_sd_sync[SYNC_STAGES-2:0], i_i2si_sd};
      r_sck_d    <= r_sck_sync[SYNC_STAGES-1];
      r_sck_rise <= r_sck_sync[SYNC_STAGES-1] & ~r_sck_d;
      r_ws_smp   <= r_ws_sync[SYNC_STAGES-1];
      r_sd_smp   <= r_sd_sync[SYNC_STAGES-1];
      if (r_sck_rise) begin
        r_ws_prev <= r_ws_smp;
      end
    end
  end

  assign w_ws_chg = r_sck_rise & (r_ws_smp != r_ws_prev);

  // Mask walks from MSB down and becomes zero once the word is full, so
  // extra bits fall away and short words stay left-justified.
  assign w_mask = MSB_MASK >> r_bit_cnt;
  assign w_word = r_sd_smp ? (r_shreg | w_mask) : r_shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_SYNC;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_lft_hold <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bit_cnt  <= w_cnt_nxt;
      r_lft_hold <= w_lft_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_cnt_nxt    = r_bit_cnt;
    w_lft_nxt    = r_lft_hold;
    w_frame_done = 1'b0;
    if (!i_i2si_en) begin
      w_state_nxt = ST_SYNC;
      w_shreg_nxt = '0;
      w_cnt_nxt   = '0;
      w_lft_nxt   = '0;
    end else begin
      case (r_state)
        ST_SYNC: begin
          if (w_ws_chg && !r_ws_smp) begin
            w_state_nxt = ST_LEFT;
            w_shreg_nxt = '0;
            w_cnt_nxt   = '0;
          end
        end
        ST_LEFT, ST_RIGHT: begin
          if (w_ws_chg) begin
            // The bit on the ws change is this word's LSB; the word ends here.
            w_shreg_nxt = '0;
            w_cnt_nxt   = '0;
            if (r_state == ST_LEFT) begin
              w_lft_nxt   = w_word;
              w_state_nxt = ST_RIGHT;
            end else begin
              w_frame_done = 1'b1;
              w_state_nxt  = ST_LEFT;
            end
          end else if (r_sck_rise) begin
            w_shreg_nxt = w_word;
            if (r_bit_cnt != CNT_MAX) begin
              w_cnt_nxt = r_bit_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = ST_SYNC;
          w_shreg_nxt = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // A transfer in the same clk frees the output register, so a new pair may
  // load without counting as an overrun.
  assign w_xfer    = r_rts & i_filt_i2si_rtr;
  assign w_load    = w_frame_done & (~r_rts | w_xfer);
  assign w_ovr_evt = w_frame_done & r_rts & ~i_filt_i2si_rtr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_lft <= '0;
      r_out_rgt <= '0;
      r_rts     <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_lft <= r_lft_hold;
        r_out_rgt <= w_word;
        r_rts     <= 1'b1;
      end else if (w_xfer) begin
        r_rts <= 1'b0;
      end
      if (w_ovr_evt) begin
        r_ovr <= 1'b1;
      end else if (i_i2si_ovr_clr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign o_i2si_filt_lft = r_out_lft;
  assign o_i2si_filt_rgt = r_out_rgt;
  assign o_i2si_filt_rts = r_rts;
  assign o_i2si_ovr      = r_ovr;

endmodule

// File: tb/tb_i2si.sv
// tb_i2si - directed bench for the i2si receiver.
module tb_i2si;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_en;
  logic        i_sck;
  logic        i_ws;
  logic        i_sd;
  logic [15:0] o_lft;
  logic [15:0] o_rgt;
  logic        o_rts;
  logic        i_rtr;
  logic        o_ovr;
  logic        i_ovr_clr;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] xq[$];

  i2si #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_i2si_en       (i_en),
    .i_i2si_sck      (i_sck),
    .i_i2si_ws       (i_ws),
    .i_i2si_sd       (i_sd),
    .o_i2si_filt_lft (o_lft),
    .o_i2si_filt_rgt (o_rgt),
    .o_i2si_filt_rts (o_rts),
    .i_filt_i2si_rtr (i_rtr),
    .o_i2si_ovr      (o_ovr),
    .i_i2si_ovr_clr  (i_ovr_clr)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so at negedge rts & rtr means a
  // transfer on the coming posedge.
  always @(negedge clk) begin
    if (o_rts === 1'b1 && i_rtr === 1'b1) xq.push_back({o_lft, o_rgt});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic ws, input logic sd);
    i_sck = 1'b0; i_ws = ws; i_sd = sd;
    tick(4);
    i_sck = 1'b1;
    tick(4);
  endtask

  // Drives the low phase of the final right LSB and raises sck; caller owns
  // the high phase.
  task automatic rise_last(input logic sd);
    i_sck = 1'b0; i_ws = 1'b0; i_sd = sd;
    tick(4);
    i_sck = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n,
                            input bit hold_last);
    for (int i = n - 1; i >= 0; i--) send_bit(i == 0, l[i]);
    for (int i = n - 1; i >= 1; i--) send_bit(1'b1, r[i]);
    if (!hold_last) send_bit(1'b0, r[0]);
  endtask

  initial begin
    logic [15:0] w;
    rst_n = 1'b0; i_en = 1'b0; i_sck = 1'b0; i_ws = 1'b0; i_sd = 1'b0;
    i_rtr = 1'b0; i_ovr_clr = 1'b0;
    tick(3);
    chk("rst_lft", o_lft, 0);
    chk("rst_rgt", o_rgt, 0);
    chk("rst_rts", o_rts, 0);
    chk("rst_ovr", o_ovr, 0);
    rst_n = 1'b1;
    tick(2);
    i_en = 1'b1; i_rtr = 1'b1;
    tick(2);

    // preamble: ws 0->1 ignored in SYNC, then 1->0 starts the left word
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_frame(32'hA5C3, 32'h1234, 16, 1'b1);
    rise_last(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); chk("lat_rts_early", o_rts, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_rts", o_rts, 1);
    chk("f1_lft", o_lft, 16'hA5C3);
    chk("f1_rgt", o_rgt, 16'h1234);
    @(posedge clk);
    @(negedge clk); chk("f1_rts_pulse", o_rts, 0);
    @(posedge clk); #1;
    chk("f1_xfer_n", xq.size(), 1);
    chk("f1_pair", xq[$], 32'hA5C3_1234);

    send_frame(32'hABCDEF, 32'h135790, 24, 1'b0);
    tick(4);
    chk("long_xfer_n", xq.size(), 2);
    chk("long_pair", xq[$], 32'hABCD_1357);

    send_frame(32'hFFF, 32'hABC, 12, 1'b0);
    tick(4);
    chk("short_xfer_n", xq.size(), 3);
    chk("short_pair", xq[$], 32'hFFF0_ABC0);

    // overrun: second frame dropped while first is held
    i_rtr = 1'b0;
    tick(1);
    send_frame(32'h1111, 32'h2222, 16, 1'b0);
    send_frame(32'h3333, 32'h4444, 16, 1'b0);
    tick(2);
    chk("ovr_rts", o_rts, 1);
    chk("ovr_lft", o_lft, 16'h1111);
    chk("ovr_rgt", o_rgt, 16'h2222);
    chk("ovr_set", o_ovr, 1);
    chk("ovr_no_xfer", xq.size(), 3);
    i_ovr_clr = 1'b1;
    tick(1);
    i_ovr_clr = 1'b0;
    chk("ovr_clr", o_ovr, 0);
    i_rtr = 1'b1;
    tick(2);
    chk("ovr_rts_drop", o_rts, 0);
    chk("ovr_xfer_n", xq.size(), 4);
    chk("ovr_pair", xq[$], 32'h1111_2222);

    // rtr rises in the clk frame_done is asserted while rts = 1
    i_rtr = 1'b0;
    tick(1);
    send_frame(32'h5555, 32'h6666, 16, 1'b0);
    send_frame(32'h7777, 32'h8888, 16, 1'b1);
    rise_last(1'b0);
    repeat (3) @(posedge clk);
    #1 i_rtr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("sim_rts", o_rts, 1);
    chk("sim_lft", o_lft, 16'h7777);
    chk("sim_rgt", o_rgt, 16'h8888);
    chk("sim_ovr", o_ovr, 0);
    @(posedge clk); #1;
    tick(2);
    chk("sim_xfer_n", xq.size(), 6);
    chk("sim_old_pair", xq[4], 32'h5555_6666);
    chk("sim_new_pair", xq[5], 32'h7777_8888);
    chk("sim_rts_drop", o_rts, 0);

    // enable dropped mid left word
    w = 16'hCAFE;
    for (int i = 15; i >= 8; i--) send_bit(1'b0, w[i]);
    i_en = 1'b0;
    tick(3);
    i_en = 1'b1;
    for (int i = 7; i >= 0; i--) send_bit(i == 0, w[i]);
    w = 16'hBEEF;
    for (int i = 15; i >= 0; i--) send_bit(i != 0, w[i]);
    tick(4);
    chk("en_no_frame", xq.size(), 6);
    send_frame(32'h9ABC, 32'hDEF0, 16, 1'b0);
    tick(4);
    chk("en_xfer_n", xq.size(), 7);
    chk("en_pair", xq[$], 32'h9ABC_DEF0);

    // reset mid-word with a frame held
    i_rtr = 1'b0;
    tick(1);
    send_frame(32'h0F0F, 32'hF0F0, 16, 1'b0);
    tick(2);
    chk("pre_rst_rts", o_rts, 1);
    w = 16'h5A5A;
    for (int i = 15; i >= 8; i--) send_bit(1'b0, w[i]);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rts", o_rts, 0);
    chk("mid_rst_lft", o_lft, 0);
    chk("mid_rst_rgt", o_rgt, 0);
    tick(3);
    rst_n = 1'b1;
    i_rtr = 1'b1;
    for (int i = 7; i >= 0; i--) send_bit(i == 0, w[i]);
    w = 16'h6B6B;
    for (int i = 15; i >= 0; i--) send_bit(i != 0, w[i]);
    tick(4);
    chk("rst_no_frame", xq.size(), 7);
    send_frame(32'h2468, 32'h1357, 16, 1'b0);
    tick(4);
    chk("rst_xfer_n", xq.size(), 8);
    chk("rst_pair", xq[$], 32'h2468_1357);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
